// File: rtl/spi_host.sv
// spi_host -- single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// A byte is started with start_strobe; tx_data and hold are captured at that
// moment. Each bit occupies 2*CLOCKS_PER_HALF_BIT clk cycles: SCK low, then
// SCK high. MISO is captured on the clk edge that raises SCK. After the eighth
// bit the received byte is published on rx_data with a one-cycle rx_strobe.
// With hold=1 the host parks in HOLD with CS still asserted, so a following
// byte continues the same transfer. With hold=0 it runs a TEARDOWN/GAP tail
// before returning to IDLE.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low
//   tx_data[7:0]   byte to send, captured with an accepted start_strobe
//   hold           captured with start_strobe; 1 = keep CS low after the byte
//   start_strobe   one-cycle start request (ignored while busy)
//   release_strobe one-cycle request to leave HOLD (ignored elsewhere)
//   busy           1 while a start_strobe would be ignored
//   rx_data[7:0]   last received byte
//   rx_strobe      one-cycle pulse when rx_data updates
//   spi_sck / spi_cs (active-low) / spi_mosi / spi_miso
// Every output comes straight from a flop.
module spi_host #(
  parameter int unsigned CLOCKS_PER_HALF_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       hold,
  input  logic       start_strobe,
  input  logic       release_strobe,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       spi_sck,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT_LOW  = 3'd1,
    SHIFT_HIGH = 3'd2,
    HOLD       = 3'd3,
    TEARDOWN   = 3'd4,
    GAP        = 3'd5
  } state_e;

  // Reload value of the half-period down-counter.
  localparam logic [7:0] HALF_LAST = 8'(CLOCKS_PER_HALF_BIT - 1);

  state_e     state_q, state_d;
  logic [7:0] half_cnt_q, half_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       hold_q, hold_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_strobe_q, rx_strobe_d;
  logic       sck_q, sck_d;
  logic       cs_q, cs_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    half_cnt_d  = half_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    sck_d       = sck_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE, HOLD: begin
        // Start wins over release when both arrive in HOLD; CS never
        // deasserts between held bytes.
        if (start_strobe) begin
          state_d    = SHIFT_LOW;
          tx_sh_d    = tx_data;
          hold_d     = hold;
          bit_cnt_d  = 3'd7;
          half_cnt_d = HALF_LAST;
          cs_d       = 1'b0;
          sck_d      = 1'b0;
          mosi_d     = tx_data[7];
          busy_d     = 1'b1;
        end else if (state_q == HOLD && release_strobe) begin
          state_d    = TEARDOWN;
          half_cnt_d = HALF_LAST;
          busy_d     = 1'b1;
        end
      end
      SHIFT_LOW: begin
        if (half_cnt_q == 8'd0) begin
          // This edge raises SCK, so it is also the MISO sample point.
          state_d    = SHIFT_HIGH;
          sck_d      = 1'b1;
          half_cnt_d = HALF_LAST;
          rx_sh_d    = {rx_sh_q[6:0], spi_miso};
        end else begin
          half_cnt_d = half_cnt_q - 8'd1;
        end
      end
      SHIFT_HIGH: begin
        if (half_cnt_q == 8'd0) begin
          sck_d      = 1'b0;
          half_cnt_d = HALF_LAST;
          if (bit_cnt_q != 3'd0) begin
            // Next bit goes out on the same edge that drops SCK.
            state_d   = SHIFT_LOW;
            bit_cnt_d = bit_cnt_q - 3'd1;
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            mosi_d    = tx_sh_q[6];
          end else begin
            rx_data_d   = rx_sh_q;
            rx_strobe_d = 1'b1;
            mosi_d      = 1'b0;
            if (hold_q) begin
              state_d = HOLD;
              busy_d  = 1'b0;
            end else begin
              state_d = TEARDOWN;
            end
          end
        end else begin
          half_cnt_d = half_cnt_q - 8'd1;
        end
      end
      TEARDOWN: begin
        mosi_d = 1'b0;
        if (half_cnt_q == 8'd0) begin
          state_d    = GAP;
          cs_d       = 1'b1;
          half_cnt_d = HALF_LAST;
        end else begin
          half_cnt_d = half_cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (half_cnt_q == 8'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          half_cnt_d = half_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      half_cnt_q  <= 8'd0;
      bit_cnt_q   <= 3'd0;
      tx_sh_q     <= 8'd0;
      rx_sh_q     <= 8'd0;
      hold_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_cnt_q  <= half_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign rx_data   = rx_data_q;
  assign rx_strobe = rx_strobe_q;
  assign spi_sck   = sck_q;
  assign spi_cs    = cs_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host. Two instances: k=0 with N=2 and MISO looped back from
// MOSI, k=1 with N=1 and MISO tied high. A timeline model (cycles since the
// accepted start, position in the CS tail) predicts every output each cycle.
// Directed scenarios add literal expectations for latency, edge counts and
// received bytes.
module tb_spi_host;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, start, hold, rel, miso;
  logic [1:0] busy, rxs, sck, cs, mosi;
  logic [7:0] tx  [2];
  logic [7:0] rxd [2];

  assign miso[0] = mosi[0];
  assign miso[1] = 1'b1;

  spi_host #(.CLOCKS_PER_HALF_BIT(2)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .tx_data(tx[0]), .hold(hold[0]),
    .start_strobe(start[0]), .release_strobe(rel[0]), .busy(busy[0]),
    .rx_data(rxd[0]), .rx_strobe(rxs[0]), .spi_sck(sck[0]), .spi_cs(cs[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]));

  spi_host #(.CLOCKS_PER_HALF_BIT(1)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .tx_data(tx[1]), .hold(hold[1]),
    .start_strobe(start[1]), .release_strobe(rel[1]), .busy(busy[1]),
    .rx_data(rxd[1]), .rx_strobe(rxs[1]), .spi_sck(sck[1]), .spi_cs(cs[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic int nk(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Model: m_t = cycle index within the byte (1..16N, 0 = no byte running),
  // m_tail = cycle index within teardown+gap (1..2N, 0 = none).
  int         m_t    [2] = '{0, 0};
  int         m_tail [2] = '{0, 0};
  bit         m_inhold [2] = '{0, 0};
  bit         m_hold [2] = '{0, 0};
  bit         m_rxs  [2] = '{0, 0};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};
  logic [7:0] m_acc  [2] = '{8'h00, 8'h00};
  logic [7:0] m_rxd  [2] = '{8'h00, 8'h00};

  // Observation counters used by the literal checks.
  int   cyc [2], first_rxs [2], last_cs_lo [2], first_idle [2];
  int   cs_hi [2], sck_rise [2], rxs_cnt [2];
  logic prev_sck [2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int k, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, k, $time, got, exp);
    end
  endtask

  task automatic compare(input int k);
    int   n, idx;
    logic e_cs, e_sck, e_mosi, e_busy;
    n      = nk(k);
    e_cs   = !(m_t[k] > 0 || m_inhold[k] || (m_tail[k] >= 1 && m_tail[k] <= n));
    e_sck  = (m_t[k] > 0) && ((((m_t[k] - 1) / n) % 2) == 1);
    e_busy = (m_t[k] > 0) || (m_tail[k] > 0);
    e_mosi = 1'b0;
    if (m_t[k] > 0) begin
      idx    = 7 - (m_t[k] - 1) / (2 * n);
      e_mosi = m_data[k][idx];
    end
    chk("cs", k, 8'(cs[k]), 8'(e_cs));
    chk("sck", k, 8'(sck[k]), 8'(e_sck));
    chk("busy", k, 8'(busy[k]), 8'(e_busy));
    chk("rx_strobe", k, 8'(rxs[k]), 8'(m_rxs[k]));
    chk("rx_data", k, rxd[k], m_rxd[k]);
    if (m_t[k] > 0 || e_cs) chk("mosi", k, 8'(mosi[k]), 8'(e_mosi));
  endtask

  task automatic observe(input int k);
    if (sck[k] === 1'b1 && prev_sck[k] === 1'b0) sck_rise[k]++;
    prev_sck[k] = sck[k];
    if (rxs[k] === 1'b1) begin
      rxs_cnt[k]++;
      if (first_rxs[k] < 0) first_rxs[k] = cyc[k];
    end
    if (cs[k] === 1'b0) last_cs_lo[k] = cyc[k];
    else if (cyc[k] > 0) cs_hi[k]++;
    if (busy[k] === 1'b0 && cyc[k] > 0 && first_idle[k] < 0) first_idle[k] = cyc[k];
    cyc[k]++;
  endtask

  // Advance the model by one clk edge using the inputs of the current cycle.
  task automatic model_step(input int k);
    int n;
    bit busy_now;
    n        = nk(k);
    busy_now = (m_t[k] > 0) || (m_tail[k] > 0);
    m_rxs[k] = 1'b0;
    if (rst_n[k] !== 1'b1) begin
      m_t[k] = 0; m_tail[k] = 0; m_inhold[k] = 0; m_rxd[k] = 8'h00;
    end else if (start[k] && !busy_now) begin
      m_t[k] = 1; m_data[k] = tx[k]; m_hold[k] = hold[k];
      m_inhold[k] = 0; m_tail[k] = 0;
    end else if (m_t[k] > 0) begin
      if (m_t[k] % (2 * n) == n) m_acc[k] = {m_acc[k][6:0], miso[k]};
      if (m_t[k] == 16 * n) begin
        m_t[k] = 0; m_rxs[k] = 1'b1; m_rxd[k] = m_acc[k];
        if (m_hold[k]) m_inhold[k] = 1; else m_tail[k] = 1;
      end else begin
        m_t[k]++;
      end
    end else if (m_inhold[k] && rel[k]) begin
      m_inhold[k] = 0; m_tail[k] = 1;
    end else if (m_tail[k] > 0) begin
      m_tail[k] = (m_tail[k] == 2 * n) ? 0 : m_tail[k] + 1;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (chk_en) compare(k);
      observe(k);
      model_step(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs(input int k);
    cyc[k] = 0; first_rxs[k] = -1; last_cs_lo[k] = -1; first_idle[k] = -1;
    cs_hi[k] = 0; sck_rise[k] = 0; rxs_cnt[k] = 0;
  endtask

  task automatic pulse_start(input int k, input logic [7:0] d, input logic h);
    tx[k] = d; hold[k] = h; start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic h);
    clear_obs(k);
    pulse_start(k, d, h);
  endtask

  initial begin
    rst_n = 2'b00; start = '0; hold = '0; rel = '0;
    tx[0] = 8'h00; tx[1] = 8'h00;
    clear_obs(0); clear_obs(1);
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_cs", k, 8'(cs[k]), 8'h01);
      chk("rst_sck", k, 8'(sck[k]), 8'h00);
      chk("rst_mosi", k, 8'(mosi[k]), 8'h00);
      chk("rst_busy", k, 8'(busy[k]), 8'h00);
      chk("rst_rxs", k, 8'(rxs[k]), 8'h00);
      chk("rst_rxd", k, rxd[k], 8'h00);
    end
    rst_n = 2'b11;
    repeat (2) tick();

    // Loopback A5, hold=0: timing of strobe, CS window and return to idle.
    send(0, 8'hA5, 1'b0);
    chk("first_cs", 0, 8'(cs[0]), 8'h00);
    chk("first_mosi", 0, 8'(mosi[0]), 8'h01);
    chk("first_sck", 0, 8'(sck[0]), 8'h00);
    repeat (40) tick();
    chk("a5_rxs_cycle", 0, 8'(first_rxs[0]), 8'd33);
    chk("a5_last_cs_lo", 0, 8'(last_cs_lo[0]), 8'd34);
    chk("a5_idle_cycle", 0, 8'(first_idle[0]), 8'd37);
    chk("a5_rxd", 0, rxd[0], 8'hA5);
    chk("a5_sck_rises", 0, 8'(sck_rise[0]), 8'd8);

    // Starts while busy and a release outside HOLD are ignored.
    send(0, 8'h96, 1'b0);
    repeat (2) tick();
    pulse_start(0, 8'h11, 1'b1);
    rel[0] = 1'b1; tick(); rel[0] = 1'b0;
    repeat (29) tick();
    pulse_start(0, 8'h22, 1'b1);
    pulse_start(0, 8'h33, 1'b1);
    repeat (4) tick();
    rel[0] = 1'b1; tick(); rel[0] = 1'b0;
    tick();
    chk("busy_sck_rises", 0, 8'(sck_rise[0]), 8'd8);
    chk("busy_rxs_cnt", 0, 8'(rxs_cnt[0]), 8'd1);
    chk("busy_rxd", 0, rxd[0], 8'h96);

    // HOLD, then start and release together: start wins, CS stays low.
    send(0, 8'h3C, 1'b1);
    repeat (35) tick();
    chk("hold_cs", 0, 8'(cs[0]), 8'h00);
    chk("hold_busy", 0, 8'(busy[0]), 8'h00);
    chk("hold_rxd", 0, rxd[0], 8'h3C);
    clear_obs(0);
    rel[0] = 1'b1;
    pulse_start(0, 8'hC3, 1'b0);
    rel[0] = 1'b0;
    repeat (40) tick();
    chk("sim_rxs_cycle", 0, 8'(first_rxs[0]), 8'd33);
    chk("sim_last_cs_lo", 0, 8'(last_cs_lo[0]), 8'd34);
    chk("sim_rxd", 0, rxd[0], 8'hC3);

    // HOLD then release: N more CS-low cycles, N CS-high, then idle.
    send(0, 8'h5A, 1'b1);
    repeat (34) tick();
    clear_obs(0);
    rel[0] = 1'b1; tick(); rel[0] = 1'b0;
    repeat (8) tick();
    chk("rel_last_cs_lo", 0, 8'(last_cs_lo[0]), 8'd2);
    chk("rel_idle_cycle", 0, 8'(first_idle[0]), 8'd5);
    chk("rel_rxd", 0, rxd[0], 8'h5A);

    // Reset in cycle 10 of a byte aborts it.
    send(0, 8'hFF, 1'b0);
    repeat (9) tick();
    rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1;
    chk("abort_cs", 0, 8'(cs[0]), 8'h01);
    chk("abort_sck", 0, 8'(sck[0]), 8'h00);
    chk("abort_mosi", 0, 8'(mosi[0]), 8'h00);
    chk("abort_busy", 0, 8'(busy[0]), 8'h00);
    repeat (40) tick();
    chk("abort_rxs_cnt", 0, 8'(rxs_cnt[0]), 8'd0);

    // N=1, MISO high: two held bytes back to back, second start in strobe cycle.
    send(1, 8'h00, 1'b1);
    repeat (16) tick();
    chk("b2b_rxs1", 1, 8'(rxs[1]), 8'h01);
    chk("b2b_rxd1", 1, rxd[1], 8'hFF);
    pulse_start(1, 8'h3C, 1'b1);
    repeat (16) tick();
    chk("b2b_rxs2", 1, 8'(rxs[1]), 8'h01);
    tick();
    chk("b2b_sck_rises", 1, 8'(sck_rise[1]), 8'd16);
    chk("b2b_rxs_cnt", 1, 8'(rxs_cnt[1]), 8'd2);
    chk("b2b_cs_hi", 1, 8'(cs_hi[1]), 8'd0);
    chk("b2b_rxd2", 1, rxd[1], 8'hFF);
    rel[1] = 1'b1; tick(); rel[1] = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_host.md
SPI_HOST -- requirements
Module: spi_host

Interface
REQ-001 SHALL have parameter CLOCKS_PER_HALF_BIT, default 4, clk cycles per SCK half-period (N below); legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port tx_data  input  8  byte to transmit, sampled on an accepted start_strobe.
REQ-005 SHALL have port hold  input  1  sampled with start_strobe; 1 = keep spi_cs asserted after the byte.
REQ-006 SHALL have port start_strobe  input  1  one-cycle request to begin a byte.
REQ-007 SHALL have port release_strobe  input  1  one-cycle request to deassert spi_cs from HOLD.
REQ-008 SHALL have port busy  output  1  high when start_strobe would be ignored.
REQ-009 SHALL have port rx_data  output  8  last received byte, stable until the next rx_strobe.
REQ-010 SHALL have port rx_strobe  output  1  one-cycle pulse when rx_data is updated.
REQ-011 SHALL have ports spi_sck output 1, spi_cs output 1 (active-low), spi_mosi output 1, spi_miso input 1.

Function
REQ-012 SHALL implement SPI mode 0, MSB first: MOSI changes while SCK low; MISO sampled on the clk edge that drives SCK high.
REQ-013 SHALL use states IDLE, SHIFT_LOW, SHIFT_HIGH, HOLD, TEARDOWN, GAP.
REQ-014 IDLE/HOLD: busy=0; start_strobe in either -> SHIFT_LOW, latch tx_data and hold, bit counter=7.
REQ-015 start_strobe accepted in cycle 0 SHALL give, from cycle 1: spi_cs=0, spi_mosi=tx_data[7], spi_sck=0.
REQ-016 SHIFT_LOW lasts N cycles (sck=0), SHIFT_HIGH lasts N cycles (sck=1); one bit = 2N cycles; byte occupies cycles 1..16N.
REQ-017 On leaving SHIFT_HIGH with bits remaining, SHALL shift next bit onto spi_mosi in the same cycle sck returns low.
REQ-018 On leaving the 8th SHIFT_HIGH, SHALL update rx_data and pulse rx_strobe in cycle 16N+1, then be in HOLD (hold=1) or TEARDOWN (hold=0).
REQ-019 TEARDOWN: cs=0, sck=0 for N cycles, then GAP: cs=1 for N cycles, busy=1; then IDLE.
REQ-020 HOLD: cs=0, sck=0, busy=0; release_strobe -> TEARDOWN; start_strobe and release_strobe together: start wins.
REQ-021 start_strobe while busy=1 SHALL be ignored with no effect on state or latched data.
REQ-022 release_strobe outside HOLD SHALL be ignored.
REQ-023 start_strobe in the rx_strobe cycle with prior hold=1 SHALL be accepted (back-to-back bytes, no cs glitch).
REQ-024 busy SHALL be 1 in SHIFT_LOW, SHIFT_HIGH, TEARDOWN, GAP.
REQ-025 Half-period counter SHALL be 8 bits, count N-1 down to 0; bit counter 3 bits; no other arithmetic.
REQ-026 spi_mosi SHALL be 0 whenever spi_cs=1.

Reset
REQ-027 While reset=0 at a clk edge: state=IDLE, spi_cs=1, spi_sck=0, spi_mosi=0, busy=0, rx_strobe=0, rx_data=8'h00.
REQ-028 Reset mid-byte SHALL abort with no rx_strobe and no SCK pulse shorter than one clk.

Structure
REQ-029 State encodings SHALL be local parameters; no shared package constants required.
REQ-030 SHALL be a single module with no sub-modules; all outputs registered.

Verification
REQ-031 N=2, miso=mosi loopback, start tx_data=8'hA5 hold=0 -> rx_data=8'hA5, rx_strobe at cycle 33, cs=0 cycles 1..34, cs=1 cycles 35..36, busy=0 from cycle 37.
REQ-032 N=1, miso tied 1, start 8'h00 hold=1 then start 8'h3C at rx_strobe cycle -> rx_data 8'hFF twice, cs never high between bytes, 16 SCK rising edges.
REQ-033 HOLD then release_strobe -> cs=0 N more cycles, then cs=1 N cycles, busy=0 after.
REQ-034 start_strobe repeated during busy -> ignored; exactly 8 SCK rising edges, rx_strobe once.
REQ-035 reset=0 at cycle 10 of a byte -> next cycle cs=1, sck=0, mosi=0, busy=0; no rx_strobe.
REQ-036 Simultaneous start_strobe and release_strobe in HOLD -> new byte starts, cs stays 0.
